// File: rtl/wb_soc_initiator_if.sv
// Bundle of command, response and Wishbone B3 classic signals for wb_soc_initiator.
// The master modport is the initiator's view; the slave modport is the requester/interconnect side.
interface wb_soc_initiator_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_we_i;
  logic [31:0] req_adr_i;
  logic [31:0] req_dat_i;
  logic [3:0]  req_sel_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_dat_o;
  logic        rsp_err_o;
  logic        rsp_timeout_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic [2:0]  wb_cti_o;
  logic [1:0]  wb_bte_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;
  logic        wb_rty_i;

  modport master (
    input  req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, rsp_ready_i,
           wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    output req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
  );

  modport slave (
    output req_valid_i, req_we_i, req_adr_i, req_dat_i, req_sel_i, rsp_ready_i,
           wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i,
    input  req_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_timeout_o,
           wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o
  );
endinterface

// File: rtl/wb_soc_initiator.sv
// Single-outstanding Wishbone B3 classic master: one request in, one single-beat cycle out,
// with bounded retry and a stb timeout so an absent slave cannot hang the requester.
module wb_soc_initiator #(
  parameter int TIMEOUT   = 255,
  parameter int MAX_RETRY = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  wb_soc_initiator_if.master   bus
);
  localparam logic [16:0] TMO  = 17'(TIMEOUT);
  localparam logic [3:0]  MAXR = 4'(MAX_RETRY);

  typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] adr_q, dat_q;
  logic [3:0]  sel_q;
  logic        we_q, latch;
  logic [15:0] tcnt, tcnt_nxt;
  logic [3:0]  rcnt, rcnt_nxt;
  logic [31:0] rdat_q, rdat_nxt;
  logic        err_q, err_nxt, to_q, to_nxt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= IDLE;
      adr_q  <= '0;
      dat_q  <= '0;
      sel_q  <= '0;
      we_q   <= 1'b0;
      tcnt   <= '0;
      rcnt   <= '0;
      rdat_q <= '0;
      err_q  <= 1'b0;
      to_q   <= 1'b0;
    end else begin
      state  <= state_nxt;
      tcnt   <= tcnt_nxt;
      rcnt   <= rcnt_nxt;
      rdat_q <= rdat_nxt;
      err_q  <= err_nxt;
      to_q   <= to_nxt;
      if (latch) begin
        adr_q <= bus.req_adr_i;
        dat_q <= bus.req_dat_i;
        sel_q <= bus.req_sel_i;
        we_q  <= bus.req_we_i;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    tcnt_nxt  = tcnt;
    rcnt_nxt  = rcnt;
    rdat_nxt  = rdat_q;
    err_nxt   = err_q;
    to_nxt    = to_q;
    latch     = 1'b0;
    case (state)
      IDLE: if (bus.req_valid_i) begin
        latch     = 1'b1;
        tcnt_nxt  = '0;
        rcnt_nxt  = '0;
        state_nxt = BUS;
      end
      BUS: begin
        // err beats ack beats rty when several land in the same cycle
        if (bus.wb_err_i) begin
          {err_nxt, to_nxt, rdat_nxt} = {1'b1, 1'b0, 32'd0};
          state_nxt = RESP;
        end else if (bus.wb_ack_i) begin
          {err_nxt, to_nxt} = 2'b00;
          rdat_nxt  = we_q ? 32'd0 : bus.wb_dat_i;
          state_nxt = RESP;
        end else if (bus.wb_rty_i) begin
          if (rcnt < MAXR) begin
            rcnt_nxt  = rcnt + 4'd1;
            state_nxt = BACKOFF;
          end else begin
            {err_nxt, to_nxt, rdat_nxt} = {1'b1, 1'b0, 32'd0};
            state_nxt = RESP;
          end
        end else begin
          if (tcnt != 16'hFFFF) tcnt_nxt = tcnt + 16'd1;
          if ({1'b0, tcnt} + 17'd1 == TMO) begin
            {err_nxt, to_nxt, rdat_nxt} = {1'b1, 1'b1, 32'd0};
            state_nxt = RESP;
          end
        end
      end
      BACKOFF: begin
        tcnt_nxt  = '0;
        state_nxt = BUS;
      end
      RESP: if (bus.rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and strobe outputs decode straight from the state register.
  assign bus.req_ready_o   = (state == IDLE);
  assign bus.wb_cyc_o      = (state == BUS);
  assign bus.wb_stb_o      = (state == BUS);
  assign bus.rsp_valid_o   = (state == RESP);
  assign bus.rsp_dat_o     = rdat_q;
  assign bus.rsp_err_o     = err_q;
  assign bus.rsp_timeout_o = to_q;
  assign bus.wb_adr_o      = adr_q;
  assign bus.wb_dat_o      = dat_q;
  assign bus.wb_sel_o      = sel_q;
  assign bus.wb_we_o       = we_q;
  assign bus.wb_cti_o      = 3'b000;
  assign bus.wb_bte_o      = 2'b00;
endmodule

// File: tb/tb_wb_soc_initiator.sv
// Bench for wb_soc_initiator: directed vector table, randomized scripts checked
// against a transaction-level model, plus reset and idle-termination sequences.
module tb_wb_soc_initiator;
  localparam int TMO  = 8;
  localparam int MAXR = 3;
  localparam logic [2:0] T_NONE = 3'd0, T_ACK = 3'd1, T_ERR = 3'd2, T_RTY = 3'd3, T_AE = 3'd4;

  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;

  wb_soc_initiator_if bus();
  wb_soc_initiator #(.TIMEOUT(TMO), .MAX_RETRY(MAXR)) dut (.clk_i(clk_i), .rst_ni(rst_ni), .bus(bus));

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic            we;
    logic [31:0]     adr, dat;
    logic [3:0]      sel;
    logic [31:0]     rd;
    logic [3:0][2:0] term;   // slave reaction per strobe attempt, slot 0 first
    logic [3:0][7:0] waits;  // wait states before that reaction
    int              rdly;
    logic            e_err, e_to;
    logic [31:0]     e_dat;
    int              e_lat, e_nstb, e_stbc;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_wb();
    bus.wb_ack_i = 1'b0;
    bus.wb_err_i = 1'b0;
    bus.wb_rty_i = 1'b0;
    bus.wb_dat_i = $urandom;
  endtask

  function automatic vec_t mk(logic we, logic [31:0] adr, logic [31:0] dat, logic [3:0] sel,
                              logic [31:0] rd, logic [3:0][2:0] term, logic [3:0][7:0] waits,
                              int rdly, logic ee, logic eto, logic [31:0] ed,
                              int lat, int nstb, int stbc);
    vec_t v;
    v.we = we; v.adr = adr; v.dat = dat; v.sel = sel; v.rd = rd;
    v.term = term; v.waits = waits; v.rdly = rdly;
    v.e_err = ee; v.e_to = eto; v.e_dat = ed;
    v.e_lat = lat; v.e_nstb = nstb; v.e_stbc = stbc;
    return v;
  endfunction

  // Transaction-level reference: walk the slave's reaction per attempt.
  function automatic vec_t model(vec_t vi);
    vec_t v = vi;
    int stbc = 0;
    int a;
    v.e_err = 1'b0; v.e_to = 1'b0; v.e_dat = '0;
    for (a = 0; a < 4; a++) begin
      if (v.term[a] == T_NONE || int'(v.waits[a]) >= TMO) begin
        stbc += TMO; v.e_err = 1'b1; v.e_to = 1'b1; break;
      end
      stbc += int'(v.waits[a]) + 1;
      if (v.term[a] == T_ERR || v.term[a] == T_AE) begin v.e_err = 1'b1; break; end
      if (v.term[a] == T_ACK) begin v.e_dat = v.we ? 32'd0 : v.rd; break; end
      if (a == MAXR) begin v.e_err = 1'b1; break; end
    end
    v.e_nstb = a + 1;
    v.e_stbc = stbc;
    v.e_lat  = 1 + stbc + a;
    return v;
  endfunction

  // Starts at a negedge with the DUT idle; ends at a negedge after the response handshake.
  task automatic run_vec(input vec_t v, input string nm);
    int  cyc_n = 1, att = -1, wcnt = 0, stbc = 0, nstb = 0, bad = 0, hbad = 0;
    bit  prev_stb = 0, done = 0;
    chk({nm, ".ready"}, 32'(bus.req_ready_o), 32'd1);
    bus.req_valid_i = 1'b1; bus.req_we_i = v.we; bus.req_adr_i = v.adr;
    bus.req_dat_i = v.dat; bus.req_sel_i = v.sel;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    bus.req_adr_i = $urandom; bus.req_dat_i = $urandom; bus.req_sel_i = 4'($urandom);
    while (!done && cyc_n < 300) begin
      clr_wb();
      if (bus.rsp_valid_o) done = 1;
      else begin
        if (bus.wb_cyc_o !== bus.wb_stb_o) bad++;
        if (bus.wb_stb_o) begin
          if (!prev_stb) begin att++; wcnt = 0; nstb++; end
          stbc++;
          if (bus.wb_adr_o !== v.adr || bus.wb_dat_o !== v.dat || bus.wb_sel_o !== v.sel ||
              bus.wb_we_o !== v.we || bus.wb_cti_o !== 3'd0 || bus.wb_bte_o !== 2'd0) bad++;
          if (att < 4 && wcnt == int'(v.waits[att])) begin
            case (v.term[att])
              T_ACK:   begin bus.wb_ack_i = 1'b1; bus.wb_dat_i = v.rd; end
              T_ERR:   bus.wb_err_i = 1'b1;
              T_RTY:   bus.wb_rty_i = 1'b1;
              T_AE:    begin bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1; bus.wb_dat_i = v.rd; end
              default: ;
            endcase
          end
          wcnt++;
        end else begin
          // stray terminations while cyc is low must be ignored
          bus.wb_ack_i = 1'($urandom_range(0, 1));
          bus.wb_err_i = 1'($urandom_range(0, 1));
          bus.wb_rty_i = 1'($urandom_range(0, 1));
        end
        prev_stb = bus.wb_stb_o;
        @(negedge clk_i);
        cyc_n++;
      end
    end
    clr_wb();
    if (!done) begin
      n_run++; n_fail++;
      $display("FAIL %s.rsp_wait: got no rsp_valid within budget, required one", nm);
    end
    chk({nm, ".lat"},   32'(cyc_n), 32'(v.e_lat));
    chk({nm, ".err"},   32'(bus.rsp_err_o), 32'(v.e_err));
    chk({nm, ".to"},    32'(bus.rsp_timeout_o), 32'(v.e_to));
    chk({nm, ".dat"},   bus.rsp_dat_o, v.e_dat);
    chk({nm, ".nstb"},  32'(nstb), 32'(v.e_nstb));
    chk({nm, ".stbc"},  32'(stbc), 32'(v.e_stbc));
    chk({nm, ".bus"},   32'(bad), 32'd0);
    for (int k = 0; k < v.rdly; k++) begin
      @(negedge clk_i);
      if (!(bus.rsp_valid_o === 1'b1 && bus.rsp_err_o === v.e_err &&
            bus.rsp_timeout_o === v.e_to && bus.rsp_dat_o === v.e_dat &&
            bus.wb_cyc_o === 1'b0 && bus.req_ready_o === 1'b0)) hbad++;
    end
    chk({nm, ".hold"}, 32'(hbad), 32'd0);
    bus.rsp_ready_i = 1'b1;
    @(negedge clk_i);
    bus.rsp_ready_i = 1'b0;
    chk({nm, ".ready_after"}, {30'd0, bus.req_ready_o, bus.rsp_valid_o}, 32'b10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t v;
    // we adr dat sel rd term waits rdly | err to dat lat nstb stbc
    tbl[0] = mk(0, 32'h9000_0004, 0, 4'hF, 32'hDEAD_BEEF, {T_NONE, T_NONE, T_NONE, T_ACK}, 32'h0, 0,
                0, 0, 32'hDEAD_BEEF, 2, 1, 1);
    tbl[1] = mk(1, 32'h0000_0010, 32'h1234_5678, 4'b0011, 32'hCAFE_F00D, {T_NONE, T_NONE, T_NONE, T_ACK},
                {8'd0, 8'd0, 8'd0, 8'd3}, 4, 0, 0, 32'h0, 5, 1, 4);
    tbl[2] = mk(0, 32'hF000_0000, 0, 4'hF, 32'h7777_7777, {T_NONE, T_NONE, T_NONE, T_NONE}, 32'h0, 1,
                1, 1, 32'h0, 9, 1, 8);
    tbl[3] = mk(0, 32'h0000_0100, 0, 4'hF, 32'h0000_A5A5, {T_NONE, T_ACK, T_RTY, T_RTY}, 32'h0, 0,
                0, 0, 32'h0000_A5A5, 6, 3, 3);
    tbl[4] = mk(1, 32'h0000_0104, 32'h0BAD_F00D, 4'hC, 32'h1111_1111, {T_RTY, T_RTY, T_RTY, T_RTY}, 32'h0, 0,
                1, 0, 32'h0, 8, 4, 4);
    tbl[5] = mk(0, 32'h0000_0200, 0, 4'hF, 32'h1122_3344, {T_NONE, T_NONE, T_NONE, T_AE}, 32'h0, 0,
                1, 0, 32'h0, 2, 1, 1);
    tbl[6] = mk(0, 32'h0000_0300, 0, 4'h1, 32'h55AA_55AA, {T_NONE, T_NONE, T_NONE, T_ACK},
                {8'd0, 8'd0, 8'd0, 8'd7}, 2, 0, 0, 32'h55AA_55AA, 9, 1, 8);
    tbl[7] = mk(0, 32'h0000_0400, 0, 4'hF, 32'h9999_9999, {T_NONE, T_NONE, T_NONE, T_RTY},
                {8'd0, 8'd0, 8'd0, 8'd2}, 0, 1, 1, 32'h0, 13, 2, 11);

    bus.req_valid_i = 0; bus.req_we_i = 0; bus.req_adr_i = 0; bus.req_dat_i = 0;
    bus.req_sel_i = 0; bus.rsp_ready_i = 0;
    clr_wb();
    #3;
    chk("rst.ready", 32'(bus.req_ready_o), 32'd1);
    chk("rst.outs", {bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o, bus.rsp_err_o,
                     bus.rsp_timeout_o, bus.wb_we_o}, 32'd0);
    chk("rst.adr", bus.wb_adr_o ^ bus.rsp_dat_o, 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // stray terminations while idle
    bus.wb_ack_i = 1'b1; bus.wb_err_i = 1'b1; bus.wb_rty_i = 1'b1;
    @(negedge clk_i);
    clr_wb();
    chk("idle_term", {30'd0, bus.req_ready_o, bus.rsp_valid_o}, 32'b10);

    for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("dir%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.we = 1'($urandom_range(0, 1)); v.adr = $urandom; v.dat = $urandom;
      v.sel = 4'($urandom); v.rd = $urandom; v.rdly = $urandom_range(0, 3);
      for (int s = 0; s < 4; s++) begin
        int r = $urandom_range(0, 9);
        v.term[s]  = (r == 0) ? T_NONE : (r <= 4) ? T_ACK : (r == 5) ? T_ERR : (r == 6) ? T_AE : T_RTY;
        v.waits[s] = 8'($urandom_range(0, 9));
      end
      run_vec(model(v), $sformatf("rnd%0d", i));
    end

    // reset in the middle of a bus cycle
    bus.req_valid_i = 1'b1; bus.req_we_i = 1'b0; bus.req_adr_i = 32'h20; bus.req_sel_i = 4'hF;
    @(posedge clk_i);
    @(negedge clk_i);
    bus.req_valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    chk("mid.cyc_before", {bus.wb_cyc_o, bus.wb_stb_o}, 32'b11);
    #2 rst_ni = 1'b0;
    #1;
    chk("mid.async", {bus.wb_cyc_o, bus.wb_stb_o, bus.rsp_valid_o}, 32'd0);
    chk("mid.ready", 32'(bus.req_ready_o), 32'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    chk("mid.ready_after", {30'd0, bus.req_ready_o, bus.wb_cyc_o}, 32'b10);
    run_vec(tbl[0], "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_soc_initiator.md
# wb_soc_initiator

Single-outstanding Wishbone B3 classic-cycle bus master for the SoC interconnect. It is the initiator end of the slave address map defined in the SoC configuration package. It takes one request at a time from a local valid/ready command port and drives a classic single-beat Wishbone cycle toward the interconnect. It returns data or error status on a valid/ready response port, with bounded retry and timeout so a missing or unmapped slave can never hang the requester.

## Interface
- TIMEOUT, 255: bus cycles with stb high and no termination before abort; range 1..65535.
- MAX_RETRY, 3: number of reissues after wb_rty_i before reporting error; 0 means the first rty is reported as error.
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  reset; asynchronous assert, active-low (one clock; reset is asynchronous and active-low).
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when high with req_valid_i.
- req_we_i  in  1  1 = write, 0 = read.
- req_adr_i  in  32  byte address.
- req_dat_i  in  32  write data.
- req_sel_i  in  4  byte selects.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  response consumed.
- rsp_dat_o  out  32  read data; 0 for writes and errors.
- rsp_err_o  out  1  bus error, retry exhaustion or timeout.
- rsp_timeout_o  out  1  error was caused by timeout.
- wb_adr_o  out  32  address.
- wb_dat_o  out  32  write data.
- wb_sel_o  out  4  byte selects.
- wb_we_o  out  1  write enable.
- wb_cyc_o  out  1  cycle.
- wb_stb_o  out  1  strobe.
- wb_cti_o  out  3  constant 3'b000.
- wb_bte_o  out  2  constant 2'b00.
- wb_dat_i  in  32  read data.
- wb_ack_i  in  1  normal termination.
- wb_err_i  in  1  error termination.
- wb_rty_i  in  1  retry termination.

## Operation
- **Reset values:** all outputs 0 except req_ready_o = 1; state IDLE; counters 0.
- **States:** IDLE, BUS, BACKOFF, RESP.
- **IDLE:**
  - req_ready_o = 1.
  - On req_valid_i, latch adr/dat/sel/we, clear the retry and timeout counters, go to BUS.
- **BUS:**
  - wb_cyc_o = wb_stb_o = 1; adr/dat/sel/we driven from the latches.
  - Termination priority within one cycle is err > ack > rty.
  - err: go to RESP with rsp_err = 1.
  - ack: go to RESP; capture wb_dat_i if read, otherwise 0.
  - rty with retry count < MAX_RETRY: increment the retry count, go to BACKOFF.
  - rty with retry count = MAX_RETRY: go to RESP with rsp_err = 1.
  - No termination: increment the timeout counter. When it reaches TIMEOUT, go to RESP with rsp_err = rsp_timeout = 1 and rsp_dat = 0.
- **BACKOFF:**
  - cyc and stb = 0 for exactly one cycle.
  - Clear the timeout counter, return to BUS.
- **RESP:**
  - rsp_valid_o = 1; rsp outputs stable until rsp_ready_i.
  - On rsp_ready_i, go to IDLE.
- Terminations arriving while cyc = 0 are ignored.
- Timeout counter width is 16 bits and saturates, no wrap.
- Retry count is 4 bits wide; MAX_RETRY ≤ 15.

## Timing
- Outputs are registered; no combinational path from wb_*_i to wb_*_o or rsp_*_o. req_ready_o is decoded from state.
- Request handshake at edge N → cyc/stb high in cycle N+1.
- ack sampled at edge M → cyc/stb low and rsp_valid_o high in cycle M+1.
- Minimum latency with a same-cycle ack: request handshake to rsp_valid_o is 2 cycles.
- Back-to-back requests: after the response handshake at edge R, req_ready_o is high in cycle R+1. Minimum spacing between new requests is 3 cycles.
- Timeout: stb high for exactly TIMEOUT cycles without termination; deasserted in cycle TIMEOUT+1.
- Each retry costs 1 BACKOFF cycle plus the re-strobe.
- Reset mid-operation: cyc/stb drop asynchronously; any pending response is discarded.

## Test plan
- **Read, zero-wait slave:** read 0x9000_0004, slave acks in the first stb cycle with 0xDEAD_BEEF → rsp_valid 2 cycles after the request handshake, rsp_dat = 0xDEAD_BEEF, rsp_err = 0, cyc high exactly 1 cycle.
- **Write, 3 wait states, rsp_ready held low 4 cycles:** write 0x0000_0010 data 0x1234_5678 sel 4'b0011 → wb_dat/sel/we stable for 4 stb cycles, rsp_dat = 0. Response holds for 4 cycles; req_ready rises the cycle after rsp_ready.
- **Unmapped address, no slave responds, TIMEOUT = 8:** → stb high exactly 8 cycles, then rsp_err = rsp_timeout = 1, rsp_dat = 0.
- **Retry, MAX_RETRY = 3:** slave asserts rty twice then ack → two 1-cycle cyc gaps, 3 strobes, rsp_err = 0. Slave asserts rty 4 times → rsp_err = 1, rsp_timeout = 0.
- **Simultaneous ack and err:** both asserted in the same cycle → rsp_err = 1, rsp_dat = 0.
- **Reset mid-operation:** assert rst_ni low mid-BUS → cyc/stb/rsp_valid low in the same cycle, req_ready = 1 after release, a following read completes normally.
